// File: rtl/afifo_tx_param.sv
// Write-side half of an asynchronous FIFO: storage, Gray write pointer, read-pointer synchroniser, full/level/overflow.
// Optional almost-full comparator enabled by defining AFIFO_TX_ALMOST_FULL_EN.
module afifo_tx_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int SYNC_STAGE = 2,
  parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
  localparam int PTR_W     = ADDR_WIDTH + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] W_DATA,
  input  logic                  WEN,
  output logic                  W_FULL,
  output logic                  W_ALMOST_FULL,
  output logic [PTR_W-1:0]      W_LEVEL,
  output logic                  W_OVERFLOW,
  input  logic                  OVF_CLR,
  input  logic [PTR_W-1:0]      R_PTR_GRAY,
  input  logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic [PTR_W-1:0]      W_PTR_GRAY,
  output logic [DATA_WIDTH-1:0] R_DATA_Tx
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 10) begin : g_bad_addr_width
    $error("afifo_tx_param: ADDR_WIDTH out of range 2..10");
  end
  if (SYNC_STAGE < 2 || SYNC_STAGE > 4) begin : g_bad_sync_stage
    $error("afifo_tx_param: SYNC_STAGE out of range 2..4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
    $error("afifo_tx_param: AF_THRESH out of range 1..DEPTH");
  end

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      w_ptr_bin;
  logic [PTR_W-1:0]      w_ptr_bin_nxt;
  logic [PTR_W-1:0]      w_ptr_gray;
  logic [PTR_W-1:0]      r_gray_sync_p [SYNC_STAGE];
  logic [PTR_W-1:0]      sync_r_gray;
  logic [PTR_W-1:0]      sync_r_bin;
  logic                  w_accept;
  logic                  w_reject;
  logic                  ovf_q;

  assign w_accept      = WEN & ~W_FULL;
  assign w_reject      = WEN & W_FULL;
  assign w_ptr_bin_nxt = w_ptr_bin + PTR_W'(1);

  // Write pointer: binary for addressing, Gray registered so the read domain never sees a glitch
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_ptr_bin  <= '0;
      w_ptr_gray <= '0;
    end else if (w_accept) begin
      w_ptr_bin  <= w_ptr_bin_nxt;
      w_ptr_gray <= bin2gray(w_ptr_bin_nxt);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && w_accept) begin
      mem[w_ptr_bin[ADDR_WIDTH-1:0]] <= W_DATA;
    end
  end

  // Read-pointer synchroniser: pure flop chain, stage 0 is the metastability catcher
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGE; i++) begin
        r_gray_sync_p[i] <= '0;
      end
    end else begin
      r_gray_sync_p[0] <= R_PTR_GRAY;
      for (int i = 1; i < SYNC_STAGE; i++) begin
        r_gray_sync_p[i] <= r_gray_sync_p[i-1];
      end
    end
  end

  assign sync_r_gray = r_gray_sync_p[SYNC_STAGE-1];
  assign sync_r_bin  = gray2bin(sync_r_gray);

  // Sticky overflow; a new rejection beats a simultaneous clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else if (w_reject) begin
      ovf_q <= 1'b1;
    end else if (OVF_CLR) begin
      ovf_q <= 1'b0;
    end
  end

  assign W_FULL     = (w_ptr_gray == {~sync_r_gray[PTR_W-1:PTR_W-2], sync_r_gray[PTR_W-3:0]});
  assign W_LEVEL    = w_ptr_bin - sync_r_bin;
  assign W_OVERFLOW = ovf_q;
  assign W_PTR_GRAY = w_ptr_gray;
  assign R_DATA_Tx  = mem[R_ADDR];

`ifdef AFIFO_TX_ALMOST_FULL_EN
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);
  assign W_ALMOST_FULL = (W_LEVEL >= AF_LVL);
`else
  assign W_ALMOST_FULL = 1'b0;
`endif

endmodule

// File: tb/tb_afifo_tx_param.sv
// Directed bench for afifo_tx_param: vector table for fill/overflow/sync latency/reset, plus a wrap sequence.
module tb_afifo_tx_param;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] W_DATA;
  logic        WEN;
  logic        W_FULL;
  logic        W_ALMOST_FULL;
  logic [3:0]  W_LEVEL;
  logic        W_OVERFLOW;
  logic        OVF_CLR;
  logic [3:0]  R_PTR_GRAY;
  logic [2:0]  R_ADDR;
  logic [3:0]  W_PTR_GRAY;
  logic [31:0] R_DATA_Tx;

`ifdef AFIFO_TX_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  afifo_tx_param #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(3),
    .SYNC_STAGE(2),
    .AF_THRESH (6)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .W_DATA       (W_DATA),
    .WEN          (WEN),
    .W_FULL       (W_FULL),
    .W_ALMOST_FULL(W_ALMOST_FULL),
    .W_LEVEL      (W_LEVEL),
    .W_OVERFLOW   (W_OVERFLOW),
    .OVF_CLR      (OVF_CLR),
    .R_PTR_GRAY   (R_PTR_GRAY),
    .R_ADDR       (R_ADDR),
    .W_PTR_GRAY   (W_PTR_GRAY),
    .R_DATA_Tx    (R_DATA_Tx)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        wen;
    logic [31:0] wdata;
    logic        clr;
    logic [3:0]  rg;
    logic        xfull;
    logic [3:0]  xlvl;
    logic [3:0]  xgray;
    logic        xovf;
  } vec_t;

  vec_t tbl [17];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] g(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge CLK);
      RST        = tbl[i].rst;
      WEN        = tbl[i].wen;
      W_DATA     = tbl[i].wdata;
      OVF_CLR    = tbl[i].clr;
      R_PTR_GRAY = tbl[i].rg;
      @(posedge CLK);
      #1;
      chk($sformatf("row%0d_full", i), W_FULL, tbl[i].xfull);
      chk($sformatf("row%0d_level", i), W_LEVEL, tbl[i].xlvl);
      chk($sformatf("row%0d_gray", i), W_PTR_GRAY, tbl[i].xgray);
      chk($sformatf("row%0d_ovf", i), W_OVERFLOW, tbl[i].xovf);
      chk($sformatf("row%0d_af", i), W_ALMOST_FULL, AF_EN && (tbl[i].xlvl >= 4'd6));
    end
  endtask

  int          wb, rb, rs0, rs1, acc;
  logic        do_wr;
  logic [3:0]  prev_gray;
  logic [31:0] q [$];
  logic [31:0] exp_d;

  initial begin
    RST = 1'b1; WEN = 1'b0; W_DATA = '0; OVF_CLR = 1'b0; R_PTR_GRAY = '0; R_ADDR = '0;

    //            rst   wen   wdata         clr   rg       full  lvl    gray     ovf
    tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 4'h0, 1'b0, 4'd0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'hA0, 1'b0, 4'h0, 1'b0, 4'd1, 4'b0001, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'hA1, 1'b0, 4'h0, 1'b0, 4'd2, 4'b0011, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'hA2, 1'b0, 4'h0, 1'b0, 4'd3, 4'b0010, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'hA3, 1'b0, 4'h0, 1'b0, 4'd4, 4'b0110, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'hA4, 1'b0, 4'h0, 1'b0, 4'd5, 4'b0111, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'hA5, 1'b0, 4'h0, 1'b0, 4'd6, 4'b0101, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'hA6, 1'b0, 4'h0, 1'b0, 4'd7, 4'b0100, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 32'hA7, 1'b0, 4'h0, 1'b1, 4'd8, 4'b1100, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'hFF, 1'b0, 4'h0, 1'b1, 4'd8, 4'b1100, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 32'h0,  1'b0, 4'h0, 1'b1, 4'd8, 4'b1100, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 4'h0, 1'b1, 4'd8, 4'b1100, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 32'hFF, 1'b1, 4'h0, 1'b1, 4'd8, 4'b1100, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 4'h2, 1'b1, 4'd8, 4'b1100, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 32'h0,  1'b0, 4'h2, 1'b0, 4'd5, 4'b1100, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 32'hEE, 1'b0, 4'h0, 1'b0, 4'd0, 4'b0000, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 32'h55, 1'b0, 4'h0, 1'b0, 4'd1, 4'b0001, 1'b0};

    run_rows(0, 8);
    for (int a = 0; a < 8; a++) begin
      R_ADDR = 3'(a);
      #1;
      chk($sformatf("fill_rd%0d", a), R_DATA_Tx, 32'hA0 + a);
    end
    run_rows(9, 14);
    R_ADDR = 3'd0;
    #1;
    chk("reject_mem0", R_DATA_Tx, 32'hA0);
    run_rows(15, 16);
    R_ADDR = 3'd0;
    #1;
    chk("post_rst_wr_addr0", R_DATA_Tx, 32'h55);

    // Wrap sequence: writes every free cycle, reads on odd cycles, read pointer fed back in Gray
    @(negedge CLK);
    RST = 1'b1; WEN = 1'b0; OVF_CLR = 1'b0; R_PTR_GRAY = '0;
    @(posedge CLK);
    #1;
    chk("wrap_rst_level", W_LEVEL, 0);
    RST = 1'b0;
    wb = 0; rb = 0; rs0 = 0; rs1 = 0; acc = 0;
    for (int cyc = 0; cyc < 200 && acc < 20; cyc++) begin
      @(negedge CLK);
      do_wr  = (((wb - rs1 + 16) % 16) != 8);
      WEN    = do_wr;
      W_DATA = 32'h100 + acc;
      if ((cyc % 2 == 1) && (rb != wb)) begin
        R_ADDR = rb[2:0];
        exp_d  = q.pop_front();
        #1;
        chk($sformatf("wrap_data_c%0d", cyc), R_DATA_Tx, exp_d);
        rb = (rb + 1) % 16;
      end
      R_PTR_GRAY = g(rb);
      prev_gray  = W_PTR_GRAY;
      @(posedge CLK);
      if (do_wr) begin
        q.push_back(32'h100 + acc);
        wb = (wb + 1) % 16;
        acc++;
      end
      rs1 = rs0;
      rs0 = rb;
      #1;
      chk($sformatf("wrap_gray_c%0d", cyc), W_PTR_GRAY, g(wb));
      chk($sformatf("wrap_level_c%0d", cyc), W_LEVEL, (wb - rs1 + 16) % 16);
      if (do_wr) chk($sformatf("wrap_onebit_c%0d", cyc), $countones(W_PTR_GRAY ^ prev_gray), 1);
    end
    chk("wrap_accepted", acc, 20);
    WEN = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afifo_tx_param.md
AFIFO_TX_PARAM -- requirements
Module: afifo_tx_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, meaning log2 of depth; DEPTH = 2**ADDR_WIDTH; legal range 2..10.
REQ-003 SHALL have parameter SYNC_STAGE, default 2, meaning the number of flops in the read-pointer synchroniser; legal range 2..4.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-2, meaning the almost-full level; legal range 1..DEPTH.
REQ-005 SHALL define PTR_W = ADDR_WIDTH+1 for all pointers.
REQ-006 SHALL use one clock and a synchronous, active-high reset: CLK input 1 (all flops on rising edge); RST input 1 (sampled on CLK rising edge).
REQ-007 Port: W_DATA input DATA_WIDTH, write data.
REQ-008 Port: WEN input 1, write request.
REQ-009 Port: W_FULL output 1, FIFO full.
REQ-010 Port: W_ALMOST_FULL output 1, level >= AF_THRESH.
REQ-011 Port: W_LEVEL output PTR_W, conservative fill count 0..DEPTH.
REQ-012 Port: W_OVERFLOW output 1, sticky overflow error.
REQ-013 Port: OVF_CLR input 1, clears W_OVERFLOW.
REQ-014 Port: R_PTR_GRAY input PTR_W, read pointer in Gray code, from the read domain.
REQ-015 Port: R_ADDR input ADDR_WIDTH, memory read address, from the read domain.
REQ-016 Port: W_PTR_GRAY output PTR_W, registered Gray write pointer, to the read domain.
REQ-017 Port: R_DATA_Tx output DATA_WIDTH, memory[R_ADDR], combinational.

Function
REQ-018 A write is accepted iff WEN & ~W_FULL; only accepted writes store W_DATA at memory[W_PTR_BIN[ADDR_WIDTH-1:0]] and increment W_PTR_BIN, modulo 2**PTR_W.
REQ-019 W_PTR_GRAY SHALL equal bin2gray(W_PTR_BIN) at all times; it updates on the same edge as W_PTR_BIN, with no glitch path (register output only).
REQ-020 R_PTR_GRAY SHALL pass through SYNC_STAGE flops, giving SYNC_R_GRAY; no other logic on that path.
REQ-021 W_FULL SHALL be asserted iff W_PTR_GRAY == {~SYNC_R_GRAY[PTR_W-1:PTR_W-2], SYNC_R_GRAY[PTR_W-3:0]}; it is combinational from registers.
REQ-022 W_LEVEL SHALL equal W_PTR_BIN - gray2bin(SYNC_R_GRAY), computed PTR_W wide modulo 2**PTR_W; it never exceeds DEPTH.
REQ-023 Write acceptance SHALL be reflected in W_FULL and W_LEVEL on the edge that accepts it, i.e. zero extra latency.
REQ-024 A read-pointer change SHALL be reflected in W_FULL and W_LEVEL exactly SYNC_STAGE cycles after it is sampled.
REQ-025 Rejected writes (WEN & W_FULL) SHALL leave the memory and pointers unchanged.
REQ-026 W_OVERFLOW SHALL be set the cycle after a rejected write and cleared the cycle after OVF_CLR; if set and clear occur in the same cycle, set wins.
REQ-027 Pointer wrap from 2**PTR_W-1 to 0 SHALL need no special handling.

Reset
REQ-028 While RST is high at a CLK edge, the block SHALL zero W_PTR_BIN, W_PTR_GRAY, all synchroniser flops and W_OVERFLOW; W_DATA/WEN are ignored.
REQ-029 Outputs after reset SHALL be: W_FULL=0, W_ALMOST_FULL=0, W_LEVEL=0, W_OVERFLOW=0, W_PTR_GRAY=0.
REQ-030 Memory contents SHALL NOT be reset; R_DATA_Tx is undefined until the location is written.
REQ-031 Reset mid-operation SHALL discard all stored data; the read domain must be reset concurrently, and the block does not detect mismatch.

Configuration
REQ-032 Macro AFIFO_TX_ALMOST_FULL_EN: when defined, W_ALMOST_FULL SHALL be (W_LEVEL >= AF_THRESH), combinational from registers.
REQ-033 When AFIFO_TX_ALMOST_FULL_EN is undefined, W_ALMOST_FULL SHALL be tied 0, no comparator is synthesised, and all other behaviour is unchanged.

Verification (DATA_WIDTH=32, ADDR_WIDTH=3, SYNC_STAGE=2, AF_THRESH=6, macro defined, R_PTR_GRAY=0 unless stated)
REQ-034 Reset, then 8 consecutive writes 0xA0..0xA7 -> after 8th edge W_FULL=1, W_LEVEL=8, W_PTR_GRAY=4'b1100; R_ADDR=0..7 reads 0xA0..0xA7.
REQ-035 Full, WEN=1 with W_DATA=0xFF -> W_PTR_GRAY stays 1100, memory unchanged, W_OVERFLOW=1 next cycle; OVF_CLR pulse -> W_OVERFLOW=0 next cycle; OVF_CLR and a rejected write in the same cycle -> W_OVERFLOW=1.
REQ-036 Write 5 words -> W_ALMOST_FULL=0; 6th write -> W_ALMOST_FULL=1 on that edge; rebuild with macro undefined -> W_ALMOST_FULL=0 throughout.
REQ-037 Full, drive R_PTR_GRAY=4'b0010 (bin 3) -> W_LEVEL=8 and W_FULL=1 for 2 cycles, then W_LEVEL=5, W_FULL=0.
REQ-038 Wrap: 20 writes interleaved with read-pointer advances -> W_PTR_BIN passes 15 to 0, W_PTR_GRAY=bin2gray each cycle, with exactly one bit changing per accepted write; data order is preserved.
REQ-039 RST high for 1 cycle with W_LEVEL=5 and W_OVERFLOW=1 -> next cycle all outputs per REQ-029; a following write lands at address 0.
